// File: rtl/sync_fifo_ext.sv
// Synchronous FIFO with level reporting, almost-full/almost-empty thresholds,
// sticky overflow/underflow flags and an optional first-word-fall-through mode.
// Storage is a plain array with one write port and one registered read port,
// so it maps onto block RAM; data_out is the RAM read register itself.
module sync_fifo_ext #(
  parameter int WIDTH         = 8,
  parameter int DEPTH         = 16,
  parameter int FWFT          = 0,
  parameter int AFULL_THRESH  = DEPTH - 2,
  parameter int AEMPTY_THRESH = 2,
  localparam int LVL_WIDTH    = $clog2(DEPTH + 1),
  localparam int ADDR_WIDTH   = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [WIDTH-1:0]     data_in,
  input  logic                 wr_en,
  input  logic                 rd_en,
  input  logic                 err_clr,
  output logic [WIDTH-1:0]     data_out,
  output logic                 empty,
  output logic                 full,
  output logic                 almost_empty,
  output logic                 almost_full,
  output logic [LVL_WIDTH-1:0] level,
  output logic                 overflow,
  output logic                 underflow
);

  localparam bit                    FWFT_MODE = (FWFT != 0);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);
  localparam logic [LVL_WIDTH-1:0]  FULL_LVL  = LVL_WIDTH'(DEPTH);
  localparam logic [LVL_WIDTH-1:0]  AF_LVL    = LVL_WIDTH'(AFULL_THRESH);
  localparam logic [LVL_WIDTH-1:0]  AE_LVL    = LVL_WIDTH'(AEMPTY_THRESH);

  logic [WIDTH-1:0]      mem [DEPTH];
  logic [WIDTH-1:0]      data_out_q;

  logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
  logic [LVL_WIDTH-1:0]  level_q, level_d;
  logic                  out_vld_q, out_vld_d;
  logic                  overflow_q, overflow_d;
  logic                  underflow_q, underflow_d;

  logic                  is_full, is_empty;
  logic                  rd_acc, wr_acc, ram_rd;
  logic [LVL_WIDTH-1:0]  stored;

  // Wrap-around pointer increment; DEPTH need not be a power of two.
  function automatic logic [ADDR_WIDTH-1:0] next_addr(input logic [ADDR_WIDTH-1:0] a);
    return (a == LAST_ADDR) ? '0 : a + 1'b1;
  endfunction

  // Acceptance decisions and RAM read-port enable.
  // In FWFT mode level counts the word held in data_out too, so the words
  // still sitting in RAM are level minus the output-valid bit. The RAM is
  // read whenever the output register is (or is about to become) free and
  // something is stored, which keeps one-word-per-cycle reads flowing.
  always_comb begin
    is_full  = (level_q == FULL_LVL);
    is_empty = FWFT_MODE ? ~out_vld_q : (level_q == '0);
    rd_acc   = rd_en & ~is_empty;
    wr_acc   = wr_en & (~is_full | rd_acc);
    stored   = level_q - LVL_WIDTH'(out_vld_q);
    ram_rd   = FWFT_MODE ? ((stored != '0) & (~out_vld_q | rd_acc)) : rd_acc;
  end

  // Next-state for pointers, level, output-valid and sticky error flags.
  always_comb begin
    wr_addr_d = wr_acc ? next_addr(wr_addr_q) : wr_addr_q;
    rd_addr_d = ram_rd ? next_addr(rd_addr_q) : rd_addr_q;

    level_d = level_q;
    case ({wr_acc, rd_acc})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase

    out_vld_d = 1'b0;
    if (FWFT_MODE) begin
      if (ram_rd)      out_vld_d = 1'b1;
      else if (rd_acc) out_vld_d = 1'b0;
      else             out_vld_d = out_vld_q;
    end

    // A fresh error in the same cycle as err_clr wins.
    overflow_d  = (overflow_q  & ~err_clr) | (wr_en & ~wr_acc);
    underflow_d = (underflow_q & ~err_clr) | (rd_en & ~rd_acc);
  end

  // Control state registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_addr_q   <= '0;
      rd_addr_q   <= '0;
      level_q     <= '0;
      out_vld_q   <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_addr_q   <= wr_addr_d;
      rd_addr_q   <= rd_addr_d;
      level_q     <= level_d;
      out_vld_q   <= out_vld_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // RAM write port; array contents are never reset.
  always_ff @(posedge clk) begin
    if (wr_acc && !reset) begin
      mem[wr_addr_q] <= data_in;
    end
  end

  // RAM read port register, doubling as data_out; cleared by reset so no
  // stale word is visible afterwards.
  always_ff @(posedge clk) begin
    if (reset) begin
      data_out_q <= '0;
    end else if (ram_rd) begin
      data_out_q <= mem[rd_addr_q];
    end
  end

  assign data_out     = data_out_q;
  assign empty        = is_empty;
  assign full         = is_full;
  assign almost_empty = (level_q <= AE_LVL);
  assign almost_full  = (level_q >= AF_LVL);
  assign level        = level_q;
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;

endmodule

// File: tb/tb_sync_fifo_ext.sv
// Testbench for sync_fifo_ext: one standard-mode and one FWFT-mode instance
// (DEPTH=10) share the same stimulus; directed scenarios plus a randomized
// run against a queue-based reference model.
module tb_sync_fifo_ext;

  localparam int DEPTH = 10;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] data_in = '0;
  logic       wr_en = 1'b0;
  logic       rd_en = 1'b0;
  logic       err_clr = 1'b0;

  logic [7:0] dout0, dout1;
  logic [3:0] lvl0, lvl1;
  logic       empty0, full0, ae0, af0, ovf0, unf0;
  logic       empty1, full1, ae1, af1, ovf1, unf1;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  sync_fifo_ext #(.WIDTH(8), .DEPTH(DEPTH), .FWFT(0)) u_std (
    .clk(clk), .reset(reset), .data_in(data_in), .wr_en(wr_en), .rd_en(rd_en),
    .err_clr(err_clr), .data_out(dout0), .empty(empty0), .full(full0),
    .almost_empty(ae0), .almost_full(af0), .level(lvl0),
    .overflow(ovf0), .underflow(unf0));

  sync_fifo_ext #(.WIDTH(8), .DEPTH(DEPTH), .FWFT(1)) u_fwft (
    .clk(clk), .reset(reset), .data_in(data_in), .wr_en(wr_en), .rd_en(rd_en),
    .err_clr(err_clr), .data_out(dout1), .empty(empty1), .full(full1),
    .almost_empty(ae1), .almost_full(af1), .level(lvl1),
    .overflow(ovf1), .underflow(unf1));

  function automatic logic [5:0] st0();
    return {empty0, full0, ae0, af0, ovf0, unf0};
  endfunction

  function automatic logic [5:0] st1();
    return {empty1, full1, ae1, af1, ovf1, unf1};
  endfunction

  task automatic cyc(input bit w, input bit r, input bit c, input logic [7:0] d);
    wr_en = w; rd_en = r; err_clr = c; data_in = d;
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cyc(0, 0, 0, 8'h00);
    cyc(0, 0, 0, 8'h00);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if ({lvl0, st0()} !== {4'd0, 6'b101000}) begin failures++;
      $display("FAIL reset_std got=%h exp=%h", {lvl0, st0()}, {4'd0, 6'b101000}); end
    checks++; if (dout0 !== 8'h00) begin failures++;
      $display("FAIL reset_std_dout got=%h exp=00", dout0); end
    checks++; if ({lvl1, st1()} !== {4'd0, 6'b101000}) begin failures++;
      $display("FAIL reset_fwft got=%h exp=%h", {lvl1, st1()}, {4'd0, 6'b101000}); end
    checks++; if (dout1 !== 8'h00) begin failures++;
      $display("FAIL reset_fwft_dout got=%h exp=00", dout1); end
  endtask

  task automatic test_fill_drain();
    logic [6:0] e;
    do_reset();
    for (int i = 0; i < DEPTH; i++) begin
      cyc(1, 0, 0, 8'(i));
      e = {4'(i + 1), (i + 1) >= 8, i == DEPTH - 1, (i + 1) <= 2};
      checks++; if ({lvl0, af0, full0, ae0} !== e) begin failures++;
        $display("FAIL fill_std i=%0d got=%h exp=%h", i, {lvl0, af0, full0, ae0}, e); end
      checks++; if ({lvl1, af1, full1, ae1} !== e) begin failures++;
        $display("FAIL fill_fwft i=%0d got=%h exp=%h", i, {lvl1, af1, full1, ae1}, e); end
    end
    cyc(1, 0, 0, 8'hFF);
    checks++; if ({lvl0, full0, ovf0} !== {4'd10, 1'b1, 1'b1}) begin failures++;
      $display("FAIL overflow_std got=%h exp=%h", {lvl0, full0, ovf0}, {4'd10, 2'b11}); end
    checks++; if ({lvl1, full1, ovf1} !== {4'd10, 1'b1, 1'b1}) begin failures++;
      $display("FAIL overflow_fwft got=%h exp=%h", {lvl1, full1, ovf1}, {4'd10, 2'b11}); end
    checks++; if ({empty1, dout1} !== {1'b0, 8'h00}) begin failures++;
      $display("FAIL fwft_head got=%h exp=000", {empty1, dout1}); end
    for (int i = 0; i < DEPTH; i++) begin
      cyc(0, 1, 0, 8'h00);
      checks++; if ({lvl0, dout0} !== {4'(9 - i), 8'(i)}) begin failures++;
        $display("FAIL drain_std i=%0d got=%h exp=%h", i, {lvl0, dout0}, {4'(9 - i), 8'(i)}); end
      if (i < DEPTH - 1) begin
        checks++; if ({lvl1, empty1, dout1} !== {4'(9 - i), 1'b0, 8'(i + 1)}) begin failures++;
          $display("FAIL drain_fwft i=%0d got=%h exp=%h", i, {lvl1, empty1, dout1}, {4'(9 - i), 1'b0, 8'(i + 1)}); end
      end else begin
        checks++; if ({lvl1, empty1} !== {4'd0, 1'b1}) begin failures++;
          $display("FAIL drain_fwft_last got=%h exp=01", {lvl1, empty1}); end
      end
    end
    checks++; if (empty0 !== 1'b1) begin failures++;
      $display("FAIL drain_std_empty got=%b exp=1", empty0); end
  endtask

  task automatic test_full_rw();
    do_reset();
    for (int i = 0; i < DEPTH; i++) cyc(1, 0, 0, 8'(i));
    for (int i = 0; i < 5; i++) begin
      cyc(1, 1, 0, 8'(10 + i));
      checks++; if ({lvl0, full0, ovf0, dout0} !== {4'd10, 2'b10, 8'(i)}) begin failures++;
        $display("FAIL full_rw_std i=%0d got=%h exp=%h", i, {lvl0, full0, ovf0, dout0}, {4'd10, 2'b10, 8'(i)}); end
      checks++; if ({lvl1, full1, ovf1, dout1} !== {4'd10, 2'b10, 8'(i + 1)}) begin failures++;
        $display("FAIL full_rw_fwft i=%0d got=%h exp=%h", i, {lvl1, full1, ovf1, dout1}, {4'd10, 2'b10, 8'(i + 1)}); end
    end
    for (int j = 0; j < DEPTH; j++) begin
      cyc(0, 1, 0, 8'h00);
      checks++; if (dout0 !== 8'(5 + j)) begin failures++;
        $display("FAIL wrap_std j=%0d got=%h exp=%h", j, dout0, 8'(5 + j)); end
      if (j < DEPTH - 1) begin
        checks++; if (dout1 !== 8'(6 + j)) begin failures++;
          $display("FAIL wrap_fwft j=%0d got=%h exp=%h", j, dout1, 8'(6 + j)); end
      end
    end
  endtask

  task automatic test_fwft_single();
    do_reset();
    cyc(1, 0, 0, 8'hA5);
    checks++; if ({empty1, lvl1} !== {1'b1, 4'd1}) begin failures++;
      $display("FAIL fwft_edge_n got=%h exp=11", {empty1, lvl1}); end
    checks++; if ({empty0, lvl0} !== {1'b0, 4'd1}) begin failures++;
      $display("FAIL std_edge_n got=%h exp=01", {empty0, lvl0}); end
    cyc(0, 0, 0, 8'h00);
    checks++; if ({empty1, dout1} !== {1'b0, 8'hA5}) begin failures++;
      $display("FAIL fwft_edge_n1 got=%h exp=0a5", {empty1, dout1}); end
    cyc(0, 1, 0, 8'h00);
    checks++; if ({empty1, lvl1} !== {1'b1, 4'd0}) begin failures++;
      $display("FAIL fwft_read got=%h exp=10", {empty1, lvl1}); end
    checks++; if ({empty0, dout0} !== {1'b1, 8'hA5}) begin failures++;
      $display("FAIL std_read got=%h exp=1a5", {empty0, dout0}); end
    cyc(0, 1, 0, 8'h00);
    checks++; if ({unf0, unf1} !== 2'b11) begin failures++;
      $display("FAIL underflow got=%b exp=11", {unf0, unf1}); end
  endtask

  task automatic test_empty_rw();
    do_reset();
    cyc(1, 1, 0, 8'h5A);
    checks++; if ({lvl0, unf0} !== {4'd1, 1'b1}) begin failures++;
      $display("FAIL empty_rw_std got=%h exp=%h", {lvl0, unf0}, {4'd1, 1'b1}); end
    checks++; if ({lvl1, unf1} !== {4'd1, 1'b1}) begin failures++;
      $display("FAIL empty_rw_fwft got=%h exp=%h", {lvl1, unf1}, {4'd1, 1'b1}); end
    cyc(0, 0, 1, 8'h00);
    checks++; if ({unf0, unf1} !== 2'b00) begin failures++;
      $display("FAIL unf_clr got=%b exp=00", {unf0, unf1}); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < 5; i++) cyc(1, 0, 0, 8'(8'h10 + i));
    checks++; if ({lvl0, lvl1} !== {4'd5, 4'd5}) begin failures++;
      $display("FAIL mid_level got=%h exp=55", {lvl0, lvl1}); end
    reset = 1'b1;
    cyc(1, 1, 0, 8'h77);
    reset = 1'b0;
    checks++; if ({lvl0, st0(), dout0} !== {4'd0, 6'b101000, 8'h00}) begin failures++;
      $display("FAIL mid_reset_std got=%h exp=%h", {lvl0, st0(), dout0}, {4'd0, 6'b101000, 8'h00}); end
    checks++; if ({lvl1, st1(), dout1} !== {4'd0, 6'b101000, 8'h00}) begin failures++;
      $display("FAIL mid_reset_fwft got=%h exp=%h", {lvl1, st1(), dout1}, {4'd0, 6'b101000, 8'h00}); end
    cyc(1, 0, 0, 8'h3C);
    cyc(0, 0, 0, 8'h00);
    checks++; if ({empty1, dout1} !== {1'b0, 8'h3C}) begin failures++;
      $display("FAIL mid_fwft_3c got=%h exp=03c", {empty1, dout1}); end
    cyc(0, 1, 0, 8'h00);
    checks++; if (dout0 !== 8'h3C) begin failures++;
      $display("FAIL mid_std_3c got=%h exp=3c", dout0); end
    checks++; if (empty1 !== 1'b1) begin failures++;
      $display("FAIL mid_fwft_empty got=%b exp=1", empty1); end
  endtask

  task automatic test_err_clr();
    do_reset();
    for (int i = 0; i < DEPTH; i++) cyc(1, 0, 0, 8'(i));
    cyc(1, 0, 0, 8'hEE);
    checks++; if ({ovf0, ovf1} !== 2'b11) begin failures++;
      $display("FAIL ovf_set got=%b exp=11", {ovf0, ovf1}); end
    cyc(0, 0, 1, 8'h00);
    checks++; if ({ovf0, ovf1} !== 2'b00) begin failures++;
      $display("FAIL ovf_clr got=%b exp=00", {ovf0, ovf1}); end
    cyc(1, 0, 1, 8'hEE);
    checks++; if ({ovf0, ovf1, lvl0, lvl1} !== {2'b11, 4'd10, 4'd10}) begin failures++;
      $display("FAIL ovf_clr_vs_write got=%h exp=%h", {ovf0, ovf1, lvl0, lvl1}, {2'b11, 4'd10, 4'd10}); end
  endtask

  task automatic test_random();
    logic [7:0] q0[$];
    logic [7:0] q1[$];
    logic [7:0] d0m, d;
    bit vis1, o0, u0, o1, u1, racc, wacc, w, r, c;
    int sz, wp;
    logic [9:0] e0, e1;
    do_reset();
    d0m = 8'h00; vis1 = 1'b0; o0 = 1'b0; u0 = 1'b0; o1 = 1'b0; u1 = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      wp = (((i / 100) % 2) == 0) ? 75 : 25;
      w = ($urandom_range(0, 99) < wp);
      r = ($urandom_range(0, 99) < (100 - wp));
      c = ($urandom_range(0, 19) == 0);
      d = 8'($urandom);
      // Standard mode: read returns head one edge later; data_out otherwise holds.
      sz = q0.size();
      racc = r && (sz > 0);
      wacc = w && ((sz < DEPTH) || racc);
      if (racc) d0m = q0.pop_front();
      if (wacc) q0.push_back(d);
      o0 = (o0 && !c) || (w && !wacc);
      u0 = (u0 && !c) || (r && !racc);
      // FWFT mode: head becomes visible one edge after it is stored.
      sz = q1.size();
      racc = r && vis1;
      wacc = w && ((sz < DEPTH) || racc);
      if (racc) begin
        void'(q1.pop_front());
        vis1 = (sz > 1);
      end else begin
        vis1 = vis1 || (sz > 0);
      end
      if (wacc) q1.push_back(d);
      o1 = (o1 && !c) || (w && !wacc);
      u1 = (u1 && !c) || (r && !racc);

      cyc(w, r, c, d);

      e0 = {4'(q0.size()), q0.size() == 0, q0.size() == DEPTH, q0.size() <= 2,
            q0.size() >= 8, o0, u0};
      e1 = {4'(q1.size()), !vis1, q1.size() == DEPTH, q1.size() <= 2,
            q1.size() >= 8, o1, u1};
      checks++; if ({lvl0, st0()} !== e0) begin failures++;
        $display("FAIL rand_std_status cyc=%0d got=%h exp=%h", i, {lvl0, st0()}, e0); end
      checks++; if (dout0 !== d0m) begin failures++;
        $display("FAIL rand_std_data cyc=%0d got=%h exp=%h", i, dout0, d0m); end
      checks++; if ({lvl1, st1()} !== e1) begin failures++;
        $display("FAIL rand_fwft_status cyc=%0d got=%h exp=%h", i, {lvl1, st1()}, e1); end
      if (vis1) begin
        checks++; if (dout1 !== q1[0]) begin failures++;
          $display("FAIL rand_fwft_data cyc=%0d got=%h exp=%h", i, dout1, q1[0]); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_fill_drain();
    test_full_rw();
    test_fwft_single();
    test_empty_rw();
    test_reset_mid();
    test_err_clr();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sync_fifo_ext.md
SYNC_FIFO_EXT -- requirements
Module: sync_fifo_ext

Interface
REQ-001 SHALL have parameter WIDTH, default 8: data word width in bits, ≥1.
REQ-002 SHALL have parameter DEPTH, default 16: storage capacity in words, ≥2, not restricted to powers of two.
REQ-003 SHALL have parameter FWFT, default 0: 0 = standard registered-read mode, 1 = first-word-fall-through mode.
REQ-004 SHALL have parameter AFULL_THRESH, default DEPTH-2: level at or above which almost_full asserts, 1..DEPTH.
REQ-005 SHALL have parameter AEMPTY_THRESH, default 2: level at or below which almost_empty asserts, 0..DEPTH-1.
REQ-006 SHALL derive LVL_WIDTH = clog2(DEPTH+1) and ADDR_WIDTH = clog2(DEPTH).
REQ-007 clk  input  1  sole clock; all state updates on its rising edge.
REQ-008 reset  input  1  synchronous, active-high reset.
REQ-009 data_in  input  WIDTH  write data.
REQ-010 wr_en  input  1  write request.
REQ-011 rd_en  input  1  read request (FWFT=0) or head-word acknowledge (FWFT=1).
REQ-012 err_clr  input  1  clears sticky error flags.
REQ-013 data_out  output  WIDTH  read data, registered.
REQ-014 empty, full, almost_empty, almost_full  output  1 each  status flags.
REQ-015 level  output  LVL_WIDTH  words accepted and not yet read.
REQ-016 overflow, underflow  output  1 each  sticky error flags.

Function
REQ-017 Write SHALL be accepted when wr_en=1 and (full=0, or a read is accepted in the same cycle); accepted word stored at wr_addr.
REQ-018 Read SHALL be accepted when rd_en=1 and empty=0.
REQ-019 wr_addr and rd_addr SHALL increment on each accepted operation and wrap from DEPTH-1 to 0.
REQ-020 level SHALL +1 on accepted write only, -1 on accepted read only, and hold on both or neither; it never exceeds DEPTH or drops below 0.
REQ-021 full SHALL equal (level==DEPTH); almost_full = (level ≥ AFULL_THRESH); almost_empty = (level ≤ AEMPTY_THRESH); all valid in the cycle after the edge that updates level.
REQ-022 FWFT=0: empty SHALL equal (level==0); on an accepted read at edge N, data_out SHALL present the head word after edge N; otherwise data_out holds.
REQ-023 FWFT=0, empty with rd_en=1 and wr_en=1: write accepted, read rejected, underflow set.
REQ-024 FWFT=1: data_out SHALL present the head word whenever empty=0; empty is the output-register valid flag, not level==0.
REQ-025 FWFT=1: a write accepted at edge N into an empty FIFO SHALL give empty=0 and data_out=that word after edge N+1; level=1 after edge N.
REQ-026 FWFT=1: a read accepted at edge N SHALL advance data_out to the next word after edge N if one is stored, otherwise set empty=1 after edge N; back-to-back reads at one word per cycle SHALL be sustained.
REQ-027 Write rejected because full SHALL set overflow; read rejected because empty SHALL set underflow; rejected operations change no other state.
REQ-028 err_clr=1 SHALL clear overflow and underflow at the next edge; a new error event in the same cycle wins and sets the flag.
REQ-029 Storage SHALL be inferable as block RAM: one synchronous write port, one synchronous read port, no reset on the array.

Reset
REQ-030 reset=1 at an edge SHALL set pointers=0, level=0, data_out=0, empty=1, full=0, almost_empty=1, almost_full=0, overflow=0, underflow=0, overriding all other inputs including mid-operation writes and reads.
REQ-031 Stored array contents SHALL NOT be cleared by reset; stale words SHALL never appear on data_out after reset without a new write.

Verification
REQ-032 DEPTH=10, FWFT=0: write 0x00..0x09 -> full=1, level=10, almost_full=1 at level 8; 11th write -> overflow=1, level stays 10; read 10 -> data_out 0x00..0x09 in order, one cycle after each rd_en.
REQ-033 DEPTH=10, full, wr_en=rd_en=1 for 5 cycles -> level stays 10, full stays 1, no overflow, output order preserved across address wrap.
REQ-034 FWFT=1: write 0xA5 to empty FIFO at edge N -> empty=0, data_out=0xA5 after edge N+1; rd_en=1 -> empty=1 next cycle; further rd_en -> underflow=1.
REQ-035 Both modes: 1000 random wr_en/rd_en cycles against a reference queue model -> data order, level, and all flags match every cycle.
REQ-036 Assert reset with level=5 mid-burst -> all outputs at reset values next cycle; subsequent write 0x3C then read returns 0x3C.
REQ-037 Set overflow, then pulse err_clr alone -> overflow=0; pulse err_clr together with a full-write -> overflow stays 1.
